// File: rtl/umi_fir_pkg.sv
// Shared UMI opcodes, error codes and register offsets for the UMI FIR filter endpoint.
package umi_fir_pkg;

   localparam logic [4:0] REQ_READ   = 5'h01;
   localparam logic [4:0] RESP_READ  = 5'h02;
   localparam logic [4:0] REQ_WRITE  = 5'h03;
   localparam logic [4:0] RESP_WRITE = 5'h04;
   localparam logic [4:0] REQ_POSTED = 5'h05;

   localparam logic [1:0] ERR_OK     = 2'b00;
   localparam logic [1:0] ERR_DECERR = 2'b10;

   localparam logic [7:0] OFF_COEFF  = 8'h00;
   localparam logic [7:0] OFF_SAMPLE = 8'h40;
   localparam logic [7:0] OFF_RESULT = 8'h48;
   localparam logic [7:0] OFF_COUNT  = 8'h50;
   localparam logic [7:0] OFF_CLEAR  = 8'h58;

endpackage

// File: rtl/umi_fir_mac.sv
// Delay line plus signed multiply-accumulate; the result register updates on the same edge
// that shifts a new sample in, using the post-shift delay line.
module umi_fir_mac #(
   parameter int unsigned NTAPS = 8,
   parameter int unsigned SW    = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [SW-1:0]                     sample,
   input  logic                              shift,
   input  logic                              clear,
   input  logic [NTAPS-1:0][SW-1:0]          coeffs,
   output logic [2*SW+$clog2(NTAPS)-1:0]     result
);

   localparam int unsigned AccW = 2 * SW + $clog2(NTAPS);

   logic [NTAPS-1:0][SW-1:0] x_q, x_d;
   logic [AccW-1:0]          result_q;
   logic signed [2*SW-1:0]   c_ext, x_ext, prod;
   logic signed [AccW-1:0]   acc;

   always_comb begin
      x_d    = x_q;
      x_d[0] = sample;
      for (int k = 1; k < NTAPS; k++) begin
         x_d[k] = x_q[k-1];
      end
   end

   // Operands are sign-extended to full product width before multiplying.
   always_comb begin
      acc   = '0;
      c_ext = '0;
      x_ext = '0;
      prod  = '0;
      for (int k = 0; k < NTAPS; k++) begin
         c_ext = {{SW{coeffs[k][SW-1]}}, coeffs[k]};
         x_ext = {{SW{x_d[k][SW-1]}}, x_d[k]};
         prod  = c_ext * x_ext;
         acc   = acc + {{(AccW-2*SW){prod[2*SW-1]}}, prod};
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         x_q      <= '0;
         result_q <= '0;
      end else if (shift) begin
         x_q      <= x_d;
         result_q <= acc;
      end
   end

   assign result = result_q;

endmodule

// File: rtl/umi_fir_filter.sv
// UMI device endpoint around an NTAPS-tap signed FIR: decode, register file, response register.
// Define UMI_FIR_SATURATE_EN to clamp the result to signed 32 bits before sign-extension.
module umi_fir_filter
   import umi_fir_pkg::*;
#(
   parameter int unsigned DW    = 128,
   parameter int unsigned AW    = 64,
   parameter int unsigned CW    = 32,
   parameter int unsigned NTAPS = 8,
   parameter int unsigned SW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          udev_req_valid,
   input  logic [CW-1:0] udev_req_cmd,
   input  logic [AW-1:0] udev_req_dstaddr,
   input  logic [AW-1:0] udev_req_srcaddr,
   input  logic [DW-1:0] udev_req_data,
   output logic          udev_req_ready,
   output logic          udev_resp_valid,
   output logic [CW-1:0] udev_resp_cmd,
   output logic [AW-1:0] udev_resp_dstaddr,
   output logic [AW-1:0] udev_resp_srcaddr,
   output logic [DW-1:0] udev_resp_data,
   input  logic          udev_resp_ready
);

   localparam int unsigned AccW = 2 * SW + $clog2(NTAPS);

   logic                     resp_valid_q, resp_valid_d;
   logic [CW-1:0]            resp_cmd_q, resp_cmd_d;
   logic [AW-1:0]            resp_dst_q, resp_dst_d;
   logic [AW-1:0]            resp_src_q, resp_src_d;
   logic [DW-1:0]            resp_data_q, resp_data_d;
   logic [NTAPS-1:0][SW-1:0] coeff_q, coeff_d;
   logic [31:0]              count_q, count_d;

   logic                     req_ready, accept;
   logic [4:0]               opcode;
   logic [7:0]               offset;
   logic                     is_read, is_write;
   logic                     shift, clear;
   logic [AccW-1:0]          acc;
   logic signed [63:0]       acc_ext;
   logic [63:0]              result64;
   logic [63:0]              rdata;
   logic                     unused_bits;

   assign req_ready = ~resp_valid_q & ~reset;
   assign accept    = udev_req_valid & req_ready;
   assign opcode    = udev_req_cmd[4:0];
   assign offset    = udev_req_dstaddr[7:0];
   assign is_read   = (opcode == REQ_READ);
   assign is_write  = (opcode == REQ_WRITE) || (opcode == REQ_POSTED);

   assign unused_bits = ^{udev_req_data[DW-1:SW], udev_req_dstaddr[AW-1:8], udev_req_cmd[CW-1:16]};

   umi_fir_mac #(
      .NTAPS (NTAPS),
      .SW    (SW)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .sample (udev_req_data[SW-1:0]),
      .shift  (shift),
      .clear  (clear),
      .coeffs (coeff_q),
      .result (acc)
   );

   assign acc_ext = {{(64-AccW){acc[AccW-1]}}, acc};

`ifdef UMI_FIR_SATURATE_EN
   localparam logic signed [63:0] SatMax = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [63:0] SatMin = 64'shFFFF_FFFF_8000_0000;

   always_comb begin
      result64 = acc_ext;
      if (acc_ext > SatMax) begin
         result64 = SatMax;
      end else if (acc_ext < SatMin) begin
         result64 = SatMin;
      end
   end
`else
   assign result64 = acc_ext;
`endif

   // Register-file writes; coefficients only affect the next sample shifted in.
   always_comb begin
      coeff_d = coeff_q;
      count_d = count_q;
      shift   = 1'b0;
      clear   = 1'b0;
      if (accept && is_write) begin
         for (int i = 0; i < NTAPS; i++) begin
            if (offset == OFF_COEFF + 8'(4 * i)) begin
               coeff_d[i] = udev_req_data[SW-1:0];
            end
         end
         if (offset == OFF_SAMPLE) begin
            shift   = 1'b1;
            count_d = count_q + 32'd1;
         end
         if (offset == OFF_CLEAR) begin
            clear   = 1'b1;
            count_d = '0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NTAPS; i++) begin
         if (offset == OFF_COEFF + 8'(4 * i)) begin
            rdata = {{(64-SW){1'b0}}, coeff_q[i]};
         end
      end
      case (offset)
         OFF_RESULT: rdata = result64;
         OFF_COUNT:  rdata = {32'b0, count_q};
         default: ;
      endcase
   end

   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_cmd_d   = resp_cmd_q;
      resp_dst_d   = resp_dst_q;
      resp_src_d   = resp_src_q;
      resp_data_d  = resp_data_q;
      if (resp_valid_q && udev_resp_ready) begin
         resp_valid_d = 1'b0;
      end
      if (accept && (opcode != REQ_POSTED)) begin
         resp_valid_d      = 1'b1;
         resp_cmd_d        = '0;
         resp_cmd_d[15:5]  = udev_req_cmd[15:5];
         resp_dst_d        = udev_req_srcaddr;
         resp_src_d        = udev_req_dstaddr;
         resp_data_d       = '0;
         if (is_read) begin
            resp_cmd_d[4:0] = RESP_READ;
            resp_data_d     = {{(DW-64){1'b0}}, rdata};
         end else begin
            resp_cmd_d[4:0]   = RESP_WRITE;
            resp_cmd_d[26:25] = is_write ? ERR_OK : ERR_DECERR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         resp_cmd_q   <= '0;
         resp_dst_q   <= '0;
         resp_src_q   <= '0;
         resp_data_q  <= '0;
         coeff_q      <= '0;
         count_q      <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_cmd_q   <= resp_cmd_d;
         resp_dst_q   <= resp_dst_d;
         resp_src_q   <= resp_src_d;
         resp_data_q  <= resp_data_d;
         coeff_q      <= coeff_d;
         count_q      <= count_d;
      end
   end

   assign udev_req_ready    = req_ready;
   assign udev_resp_valid   = resp_valid_q;
   assign udev_resp_cmd     = resp_cmd_q;
   assign udev_resp_dstaddr = resp_dst_q;
   assign udev_resp_srcaddr = resp_src_q;
   assign udev_resp_data    = resp_data_q;

endmodule

// File: tb/tb_umi_fir_filter.sv
// Table-driven scoreboard bench for umi_fir_filter, plus hand-written handshake/reset sequences.
module tb_umi_fir_filter;

   localparam logic [4:0] OpRead    = 5'h01;
   localparam logic [4:0] OpWrite   = 5'h03;
   localparam logic [4:0] OpPosted  = 5'h05;
   localparam logic [4:0] OpBad     = 5'h07;
   localparam logic [4:0] RespRead  = 5'h02;
   localparam logic [4:0] RespWrite = 5'h04;

   logic          clk = 1'b0;
   logic          reset;
   logic          udev_req_valid;
   logic [31:0]   udev_req_cmd;
   logic [63:0]   udev_req_dstaddr;
   logic [63:0]   udev_req_srcaddr;
   logic [127:0]  udev_req_data;
   logic          udev_req_ready;
   logic          udev_resp_valid;
   logic [31:0]   udev_resp_cmd;
   logic [63:0]   udev_resp_dstaddr;
   logic [63:0]   udev_resp_srcaddr;
   logic [127:0]  udev_resp_data;
   logic          udev_resp_ready;

   umi_fir_filter dut (
      .clk               (clk),
      .reset             (reset),
      .udev_req_valid    (udev_req_valid),
      .udev_req_cmd      (udev_req_cmd),
      .udev_req_dstaddr  (udev_req_dstaddr),
      .udev_req_srcaddr  (udev_req_srcaddr),
      .udev_req_data     (udev_req_data),
      .udev_req_ready    (udev_req_ready),
      .udev_resp_valid   (udev_resp_valid),
      .udev_resp_cmd     (udev_resp_cmd),
      .udev_resp_dstaddr (udev_resp_dstaddr),
      .udev_resp_srcaddr (udev_resp_srcaddr),
      .udev_resp_data    (udev_resp_data),
      .udev_resp_ready   (udev_resp_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  cmd;
      logic [63:0]  dst;
      logic [63:0]  src;
      logic [127:0] data;
   } exp_t;

   typedef struct {
      logic [4:0]  op;
      logic [7:0]  off;
      logic [63:0] wdata;
      logic [63:0] rdata;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   t0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Scoreboard: every consumed response is compared with the oldest expectation.
   always @(negedge clk) begin
      if (!reset && udev_resp_valid && udev_resp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got cmd %h want no response", udev_resp_cmd);
         end else begin
            mon_e = sb.pop_front();
            check("resp_cmd", {96'b0, udev_resp_cmd}, {96'b0, mon_e.cmd});
            check("resp_dstaddr", {64'b0, udev_resp_dstaddr}, {64'b0, mon_e.dst});
            check("resp_srcaddr", {64'b0, udev_resp_srcaddr}, {64'b0, mon_e.src});
            check("resp_data", udev_resp_data, mon_e.data);
         end
      end
   end

   function automatic void add(input logic [4:0] op, input logic [7:0] off,
                               input logic [63:0] wdata, input logic [63:0] rdata);
      vec_t v;
      v.op    = op;
      v.off   = off;
      v.wdata = wdata;
      v.rdata = rdata;
      tbl.push_back(v);
   endfunction

   task automatic do_req(input logic [4:0] op, input logic [7:0] off,
                         input logic [63:0] wdata, input logic [63:0] rexp);
      exp_t        e;
      logic [31:0] cmd;
      logic [63:0] dst, src;
      int          n;
      cmd      = $urandom;
      cmd[4:0] = op;
      dst      = {$urandom, 24'($urandom), off};
      src      = {$urandom, $urandom};
      udev_req_cmd     = cmd;
      udev_req_dstaddr = dst;
      udev_req_srcaddr = src;
      udev_req_data    = {$urandom, $urandom, wdata};
      if (op != OpPosted) begin
         e.cmd       = '0;
         e.cmd[15:5] = cmd[15:5];
         e.dst       = src;
         e.src       = dst;
         e.data      = '0;
         if (op == OpRead) begin
            e.cmd[4:0] = RespRead;
            e.data     = {64'b0, rexp};
         end else begin
            e.cmd[4:0] = RespWrite;
            if (op != OpWrite) e.cmd[26:25] = 2'b10;
         end
         sb.push_back(e);
      end
      udev_req_valid = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (udev_req_ready) break;
      end
      if (n == 50) begin
         checks++;
         errors++;
         $display("FAIL req_accept_timeout: got no accept want accept within 50 cycles");
      end
      @(posedge clk);
      #1;
      udev_req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
      @(posedge clk);
      #1;
      check(name, 128'(sb.size()), 128'd0);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1);
   end

   initial begin
      reset            = 1'b1;
      udev_req_valid   = 1'b0;
      udev_req_cmd     = '0;
      udev_req_dstaddr = '0;
      udev_req_srcaddr = '0;
      udev_req_data    = '0;
      udev_resp_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", {127'b0, udev_req_ready}, 128'd0);
      check("reset_resp_valid", {127'b0, udev_resp_valid}, 128'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state of the register file
      add(OpRead, 8'h48, 0, 0);
      add(OpRead, 8'h50, 0, 0);
      add(OpRead, 8'h00, 0, 0);
      add(OpRead, 8'h1C, 0, 0);
      // Impulse response
      add(OpWrite, 8'h00, 1, 0);
      add(OpWrite, 8'h04, 2, 0);
      add(OpWrite, 8'h08, 3, 0);
      add(OpWrite, 8'h0C, 4, 0);
      add(OpRead, 8'h04, 0, 2);
      add(OpWrite, 8'h40, 1, 0);  add(OpRead, 8'h48, 0, 1);
      add(OpWrite, 8'h40, 0, 0);  add(OpRead, 8'h48, 0, 2);
      add(OpWrite, 8'h40, 0, 0);  add(OpRead, 8'h48, 0, 3);
      add(OpWrite, 8'h40, 0, 0);  add(OpRead, 8'h48, 0, 4);
      add(OpWrite, 8'h40, 0, 0);  add(OpRead, 8'h48, 0, 0);
      add(OpRead, 8'h50, 0, 5);
      // Unmapped and write-only offsets
      add(OpWrite, 8'h90, 64'h1234, 0);
      add(OpRead, 8'h90, 0, 0);
      add(OpRead, 8'h20, 0, 0);
      add(OpRead, 8'h40, 0, 0);
      // Clear keeps coefficients
      add(OpWrite, 8'h58, 64'hDEAD, 0);
      add(OpRead, 8'h48, 0, 0);
      add(OpRead, 8'h50, 0, 0);
      add(OpRead, 8'h0C, 0, 4);
      // Step response
      for (int i = 0; i < 8; i++) add(OpWrite, 8'(4 * i), 64'h0100, 0);
      for (int i = 0; i < 8; i++) begin
         add(OpWrite, 8'h40, 64'h0010, 0);
         if (i == 0) add(OpRead, 8'h48, 0, 64'h1000);
      end
      add(OpRead, 8'h48, 0, 64'h8000);
      add(OpRead, 8'h50, 0, 8);
      // Negative coefficient; coefficient changes apply only to the next sample
      add(OpWrite, 8'h58, 0, 0);
      for (int i = 1; i < 8; i++) add(OpWrite, 8'(4 * i), 0, 0);
      add(OpWrite, 8'h00, 64'hFFFF, 0);
      add(OpWrite, 8'h40, 64'h7FFF, 0);
      add(OpRead, 8'h48, 0, 64'hFFFF_FFFF_FFFF_8001);
      add(OpWrite, 8'h00, 2, 0);
      add(OpWrite, 8'h04, 3, 0);
      add(OpRead, 8'h48, 0, 64'hFFFF_FFFF_FFFF_8001);
      add(OpWrite, 8'h40, 0, 0);
      add(OpRead, 8'h48, 0, 64'h0001_7FFD);
      // Full-scale negative inputs: 8 * (-32768 * -32768) = 2^33
      add(OpWrite, 8'h58, 0, 0);
      for (int i = 0; i < 8; i++) add(OpWrite, 8'(4 * i), 64'h8000, 0);
      for (int i = 0; i < 8; i++) add(OpPosted, 8'h40, 64'h8000, 0);
`ifdef UMI_FIR_SATURATE_EN
      add(OpRead, 8'h48, 0, 64'h0000_0000_7FFF_FFFF);
`else
      add(OpRead, 8'h48, 0, 64'h0000_0002_0000_0000);
`endif

      foreach (tbl[i]) do_req(tbl[i].op, tbl[i].off, tbl[i].wdata, tbl[i].rdata);
      wait_drain("table_drain");

      // Posted writes accepted in consecutive cycles, no responses
      do_req(OpWrite, 8'h58, 0, 0);
      wait_drain("clear_drain");
      t0 = cyc;
      do_req(OpPosted, 8'h40, 1, 0);
      do_req(OpPosted, 8'h40, 2, 0);
      do_req(OpPosted, 8'h40, 3, 0);
      check("posted_b2b_cycles", 128'(cyc - t0), 128'd3);
      wait_drain("posted_drain");

      // Backpressure: response held stable, no new accepts
      udev_resp_ready = 1'b0;
      do_req(OpRead, 8'h50, 0, 3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_resp_valid", {127'b0, udev_resp_valid}, 128'd1);
         check("bp_req_ready", {127'b0, udev_req_ready}, 128'd0);
         check("bp_resp_data", udev_resp_data, 128'd3);
      end
      @(posedge clk);
      #1;
      udev_resp_ready = 1'b1;
      wait_drain("bp_drain");

      // Bad opcode: error response, state untouched (x = 3,2,1; c = -32768)
      do_req(OpBad, 8'h40, 64'h55, 0);
      do_req(OpRead, 8'h50, 0, 3);
      do_req(OpRead, 8'h48, 0, 64'hFFFF_FFFF_FFFD_0000);
      wait_drain("bad_op_drain");

      // Reset while a response is pending
      do_req(OpWrite, 8'h58, 0, 0);
      wait_drain("clear2_drain");
      udev_resp_ready = 1'b0;
      do_req(OpRead, 8'h48, 0, 0);
      @(negedge clk);
      check("pending_resp_valid", {127'b0, udev_resp_valid}, 128'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_req_ready", {127'b0, udev_req_ready}, 128'd0);
      @(posedge clk);
      @(negedge clk);
      check("rst_drop_resp_valid", {127'b0, udev_resp_valid}, 128'd0);
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      udev_resp_ready = 1'b1;
      do_req(OpRead, 8'h00, 0, 0);
      do_req(OpRead, 8'h48, 0, 0);
      do_req(OpRead, 8'h50, 0, 0);
      wait_drain("post_reset_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
